// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding,
// the g/e/l result bundle and the bit-counter width helper.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } result_t;

  // Counter only has to hold WIDTH-1, so $clog2(WIDTH) bits suffice (min 1).
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_cmp_bit_cell.sv
// Single-bit MSB-first comparison step: latches the first differing bit
// and reports which operand is larger at that bit.
module serial_cmp_bit_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic decided,
  output logic decided_next,
  output logic gt_next,
  output logic lt_next
);

  assign decided_next = decided | (a_bit ^ b_bit);
  assign gt_next      = a_bit;
  assign lt_next      = ~a_bit;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first unsigned comparator with g/e/l cascade and
// valid/ready handshakes. Optional early exit: SERIAL_CMP_EARLY_EXIT_EN.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             g_in,
  input  logic             e_in,
  input  logic             l_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             g_out,
  output logic             e_out,
  output logic             l_out
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic             gt;
  logic             lt;
  result_t          cas;
  result_t          res;

  logic dec_cell;
  logic gt_cell;
  logic lt_cell;
  logic take;
  logic last_bit;
  logic go_done;
  logic gt_final;
  logic lt_final;

  serial_cmp_bit_cell u_cell (
    .a_bit        (sh_a[WIDTH-1]),
    .b_bit        (sh_b[WIDTH-1]),
    .decided      (decided),
    .decided_next (dec_cell),
    .gt_next      (gt_cell),
    .lt_next      (lt_cell)
  );

  assign take     = dec_cell & ~decided;
  assign last_bit = (cnt == '0);
  assign gt_final = take ? gt_cell : gt;
  assign lt_final = take ? lt_cell : lt;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign go_done = last_bit | take;
`else
  assign go_done = last_bit;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (go_done)   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Shift registers, counter, decision and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      cas     <= '0;
      res     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a    <= a;
            sh_b    <= b;
            cnt     <= CW'(WIDTH - 1);
            decided <= 1'b0;
            cas     <= '{g: g_in, e: e_in, l: l_in};
          end
        end
        SHIFT: begin
          if (take) begin
            decided <= 1'b1;
            gt      <= gt_cell;
            lt      <= lt_cell;
          end
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
          if (!last_bit) cnt <= cnt - CW'(1);
          // Cascade passes through untouched when the operands are equal.
          if (go_done) begin
            if (dec_cell) res <= '{g: gt_final, e: 1'b0, l: lt_final};
            else          res <= cas;
          end
        end
        default: ;
      endcase
    end
  end

  assign g_out = res.g;
  assign e_out = res.e;
  assign l_out = res.l;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=4 and WIDTH=8 instances).
module tb_serial_magnitude_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=4 instance
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, g_out, e_out, l_out;
  logic [3:0] a = '0, b = '0;
  logic       g_in = 1'b0, e_in = 1'b0, l_in = 1'b0;

  serial_magnitude_comparator #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .g_in(g_in), .e_in(e_in), .l_in(l_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .g_out(g_out), .e_out(e_out), .l_out(l_out)
  );

  // WIDTH=8 instance
  logic       in_valid8 = 1'b0, out_ready8 = 1'b1;
  logic       in_ready8, out_valid8, g_out8, e_out8, l_out8;
  logic [7:0] a8 = '0, b8 = '0;
  logic       g_in8 = 1'b0, e_in8 = 1'b0, l_in8 = 1'b0;

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .g_in(g_in8), .e_in(e_in8), .l_in(l_in8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .g_out(g_out8), .e_out(e_out8), .l_out(l_out8)
  );

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y,
                                       input logic [2:0] cas);
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return cas;
  endfunction

  // Edges from the accepting edge (inclusive) to the edge that raises out_valid.
  function automatic int model_lat(input int w, input logic [31:0] x, input logic [31:0] y);
    int k;
    k = w;
    for (int i = 0; i < w; i++) begin
      if (x[w-1-i] !== y[w-1-i]) begin
        k = i + 1;
        break;
      end
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    return k + 1;
`else
    return (k > 0) ? w + 1 : w + 1;
`endif
  endfunction

  // Monitor: WIDTH=4
  initial begin : mon4
    bit   seen;
    exp_t cur;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 1'b0;
      else if (out_valid) begin
        if (!seen) begin
          if (q4.size() == 0) check("w4_unexpected_valid", 32'd1, 32'd0);
          else begin
            cur  = q4.pop_front();
            seen = 1'b1;
            check("w4_result", {g_out, e_out, l_out}, cur.res);
            check("w4_latency", cyc - cur.acc + 1, cur.lat);
          end
        end else check("w4_hold", {g_out, e_out, l_out}, cur.res);
        if (out_ready) seen = 1'b0;
      end
      if (q4.size() > 0 && !seen && (cyc - q4[0].acc) > 60) begin
        check("w4_timeout", 32'd1, 32'd0);
        void'(q4.pop_front());
      end
    end
  end

  // Monitor: WIDTH=8
  initial begin : mon8
    bit   seen;
    exp_t cur;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 1'b0;
      else if (out_valid8) begin
        if (!seen) begin
          if (q8.size() == 0) check("w8_unexpected_valid", 32'd1, 32'd0);
          else begin
            cur  = q8.pop_front();
            seen = 1'b1;
            check("w8_result", {g_out8, e_out8, l_out8}, cur.res);
            check("w8_latency", cyc - cur.acc + 1, cur.lat);
          end
        end else check("w8_hold", {g_out8, e_out8, l_out8}, cur.res);
        if (out_ready8) seen = 1'b0;
      end
      if (q8.size() > 0 && !seen && (cyc - q8[0].acc) > 60) begin
        check("w8_timeout", 32'd1, 32'd0);
        void'(q8.pop_front());
      end
    end
  end

  int prev_acc = -1;
  int prev_lat = 0;

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue4(input logic [3:0] x, input logic [3:0] y, input logic [2:0] cas,
                        input bit keep_valid, input bit check_spacing);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    a = x; b = y; {g_in, e_in, l_in} = cas; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = model(32'(x), 32'(y), cas);
        e.lat = model_lat(4, 32'(x), 32'(y));
        e.acc = cyc + 1;
        q4.push_back(e);
        if (check_spacing && prev_acc >= 0) check("w4_accept_spacing", e.acc - prev_acc, prev_lat + 1);
        prev_acc = e.acc;
        prev_lat = e.lat;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("w4_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic [2:0] cas);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    a8 = x; b8 = y; {g_in8, e_in8, l_in8} = cas; in_valid8 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready8) begin
        e.res = model(32'(x), 32'(y), cas);
        e.lat = model_lat(8, 32'(x), 32'(y));
        e.acc = cyc + 1;
        q8.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("w8_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q4.size() == 0 && q8.size() == 0 && !out_valid && !out_valid8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_outputs", {g_out, e_out, l_out}, 3'b000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed basic cases
    issue4(4'd9, 4'd5, 3'b010, 1'b0, 1'b0);
    issue4(4'd6, 4'd6, 3'b010, 1'b0, 1'b0);
    issue4(4'd6, 4'd6, 3'b001, 1'b0, 1'b0);
    issue4(4'd6, 4'd6, 3'b101, 1'b0, 1'b0);
    drain("drain_basic");

    // Backpressure: result must hold for 7 stalled cycles
    out_ready = 1'b0;
    issue4(4'd3, 4'd12, 3'b010, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("bp_valid_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_out_valid_held", out_valid, 1'b1);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_before_edge", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("bp_in_ready_after", in_ready, 1'b1);
    check("bp_out_valid_after", out_valid, 1'b0);

    // Asynchronous reset mid-shift discards the transaction
    issue4(4'd15, 4'd0, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q4.delete();
    #1;
    check("async_rst_out_valid", out_valid, 1'b0);
    check("async_rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue4(4'd0, 4'd15, 3'b010, 1'b0, 1'b0);
    drain("drain_reset");

    // Full sweep with in_valid held high throughout
    prev_acc = -1;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        issue4(4'(x), 4'(y), 3'b010, 1'b1, 1'b1);
    in_valid = 1'b0;
    drain("drain_sweep");

    // WIDTH=8 cases
    issue8(8'h80, 8'h7F, 3'b010);
    issue8(8'h01, 8'h02, 3'b010);
    issue8(8'hA5, 8'hA5, 3'b100);
    drain("drain_w8");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
